// File: rtl/cpu_rp2a03_apu_frame_sequencer.sv
// APU frame counter ($4017) for the RP2A03.
// Counts CPU cycles and produces the quarter/half-frame strobes that clock
// the envelope, length counter and sweep units. Implements the 4-step and
// 5-step sequences, the frame IRQ flag and the parity-dependent delayed
// sequence reset that follows a $4017 write.
//
// Optional feature: define APU_FRAME_IRQ_EN to build the frame IRQ flag.
// Without it frame_irq_o is tied low and the inhibit bit has no effect.
//
// Ports:
//   clk_i                in   one edge per CPU cycle
//   rst_i                in   synchronous active-high reset
//   frame_reg_wr_i       in   $4017 write strobe
//   frame_reg_wr_data_i  in   [7] mode (1 = 5-step), [6] IRQ inhibit
//   status_rd_i          in   $4015 read strobe, clears the frame IRQ flag
//   quarter_frame_o      out  single-cycle quarter-frame strobe
//   half_frame_o         out  single-cycle half-frame strobe
//   frame_irq_o          out  frame IRQ flag (level)
module cpu_rp2a03_apu_frame_sequencer #(
  parameter logic [15:0] STEP1_CYCLE = 16'd7457,
  parameter logic [15:0] STEP2_CYCLE = 16'd14913,
  parameter logic [15:0] STEP3_CYCLE = 16'd22371,
  parameter logic [15:0] STEP4_CYCLE = 16'd29829,
  parameter logic [15:0] STEP5_CYCLE = 16'd37281
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_reg_wr_i,
  input  logic [7:0] frame_reg_wr_data_i,
  input  logic       status_rd_i,
  output logic       quarter_frame_o,
  output logic       half_frame_o,
  output logic       frame_irq_o
);

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } mode_e;

  logic [15:0] cnt_r, cnt_d;
  logic        parity_r;
  mode_e       mode_r, mode_d;
  logic        inhibit_r, inhibit_d;
  logic [2:0]  dly_r, dly_d;
  logic        dly_vld_r, dly_vld_d;
  logic        qf_r, qf_d;
  logic        hf_r, hf_d;
  logic        seq_reset;
  logic        wrap;
  logic [15:0] last_step;

  always_comb begin
    seq_reset = dly_vld_r && (dly_r == 3'd0);
    last_step = (mode_r == MODE_5STEP) ? STEP5_CYCLE : STEP4_CYCLE;
    wrap      = (cnt_r == last_step);

    cnt_d = wrap ? '0 : cnt_r + 16'd1;
    qf_d  = (cnt_r == STEP1_CYCLE) || (cnt_r == STEP2_CYCLE) ||
            (cnt_r == STEP3_CYCLE) || wrap;
    hf_d  = (cnt_r == STEP2_CYCLE) || wrap;

    dly_d     = dly_r;
    dly_vld_d = dly_vld_r;
    if (dly_vld_r) begin
      if (dly_r == 3'd0) dly_vld_d = 1'b0;
      else               dly_d     = dly_r - 3'd1;
    end

    // The delayed reset overrides any step match landing on the same cycle;
    // entering 5-step mode clocks the units immediately.
    if (seq_reset) begin
      cnt_d = '0;
      qf_d  = (mode_r == MODE_5STEP);
      hf_d  = (mode_r == MODE_5STEP);
    end

    mode_d    = mode_r;
    inhibit_d = inhibit_r;
    // Loading d-1 makes the reset land d cycles after the write cycle; a new
    // write simply restarts the countdown.
    if (frame_reg_wr_i) begin
      mode_d    = mode_e'(frame_reg_wr_data_i[7]);
      inhibit_d = frame_reg_wr_data_i[6];
      dly_vld_d = 1'b1;
      dly_d     = parity_r ? 3'd2 : 3'd3;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r     <= '0;
      parity_r  <= 1'b0;
      mode_r    <= MODE_4STEP;
      inhibit_r <= 1'b0;
      dly_r     <= '0;
      dly_vld_r <= 1'b0;
      qf_r      <= 1'b0;
      hf_r      <= 1'b0;
    end else begin
      cnt_r     <= cnt_d;
      parity_r  <= ~parity_r;
      mode_r    <= mode_d;
      inhibit_r <= inhibit_d;
      dly_r     <= dly_d;
      dly_vld_r <= dly_vld_d;
      qf_r      <= qf_d;
      hf_r      <= hf_d;
    end
  end

  assign quarter_frame_o = qf_r;
  assign half_frame_o    = hf_r;

`ifdef APU_FRAME_IRQ_EN
  logic irq_r, irq_d;
  logic wrap_r, wrap_d;
  logic irq_set;
  logic unused_wr_data;

  always_comb begin
    // wrap_r marks the cnt_r = 0 cycle that follows a natural 4-step wrap,
    // the third of the three consecutive set cycles.
    wrap_d  = (mode_r == MODE_4STEP) && wrap && !seq_reset;
    irq_set = (mode_r == MODE_4STEP) && !inhibit_r && !seq_reset &&
              ((cnt_r == STEP4_CYCLE - 16'd1) || (cnt_r == STEP4_CYCLE) ||
               ((cnt_r == 16'd0) && wrap_r));
    irq_d = irq_r;
    if (status_rd_i) irq_d = 1'b0;
    if (irq_set)     irq_d = 1'b1;
    if (frame_reg_wr_i && frame_reg_wr_data_i[6]) irq_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_r  <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      irq_r  <= irq_d;
      wrap_r <= wrap_d;
    end
  end

  assign frame_irq_o    = irq_r;
  assign unused_wr_data = ^frame_reg_wr_data_i[5:0];
`else
  logic unused_irq_path;

  assign frame_irq_o     = 1'b0;
  assign unused_irq_path = ^{status_rd_i, inhibit_r, frame_reg_wr_data_i[5:0]};
`endif

endmodule

// File: tb/tb_cpu_rp2a03_apu_frame_sequencer.sv
// Self-checking bench for cpu_rp2a03_apu_frame_sequencer.
// Two instances: one with the NTSC step values, one with short steps for the
// inhibit and mid-frame reset scenarios. A cycle model pushes the expected
// outputs to a scoreboard each cycle; they are popped and compared after the
// clock edge, alongside a few directed checks at key points.
module tb_cpu_rp2a03_apu_frame_sequencer;

  typedef struct packed {
    int s1;
    int s2;
    int s3;
    int s4;
    int s5;
  } prm_t;

  typedef struct packed {
    int cnt;
    bit par;
    bit mode;
    bit inh;
    bit irq;
    bit wrapped;
    int cyc;
    int rst_at;
    bit q;
    bit h;
  } mst_t;

  typedef struct {
    bit       sel;
    logic [2:0] v;
    int       cyc;
  } exp_t;

  localparam prm_t PA = '{s1: 7457, s2: 14913, s3: 22371, s4: 29829, s5: 37281};
  localparam prm_t PB = '{s1: 20, s2: 40, s3: 60, s4: 80, s5: 100};

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       a_rst, a_wr, a_rd, a_q, a_h, a_irq;
  logic [7:0] a_d;
  logic       b_rst, b_wr, b_rd, b_q, b_h, b_irq;
  logic [7:0] b_d;

  mst_t ma, mb;
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  cpu_rp2a03_apu_frame_sequencer dut (
    .clk_i               (clk_i),
    .rst_i               (a_rst),
    .frame_reg_wr_i      (a_wr),
    .frame_reg_wr_data_i (a_d),
    .status_rd_i         (a_rd),
    .quarter_frame_o     (a_q),
    .half_frame_o        (a_h),
    .frame_irq_o         (a_irq)
  );

  cpu_rp2a03_apu_frame_sequencer #(
    .STEP1_CYCLE (16'd20),
    .STEP2_CYCLE (16'd40),
    .STEP3_CYCLE (16'd60),
    .STEP4_CYCLE (16'd80),
    .STEP5_CYCLE (16'd100)
  ) dut_s (
    .clk_i               (clk_i),
    .rst_i               (b_rst),
    .frame_reg_wr_i      (b_wr),
    .frame_reg_wr_data_i (b_d),
    .status_rd_i         (b_rd),
    .quarter_frame_o     (b_q),
    .half_frame_o        (b_h),
    .frame_irq_o         (b_irq)
  );

  function automatic bit irq_exp(input bit v);
`ifdef APU_FRAME_IRQ_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  // Expected state after one cycle with the given inputs. The delayed reset
  // is tracked as an absolute cycle number: write cycle + 3 or + 4.
  function automatic mst_t model_next(input prm_t p, input mst_t s, input bit rst,
                                      input bit wr, input logic [7:0] d, input bit rd);
    mst_t n;
    bit   rst_cycle;
    bit   is_last;
    bit   set_irq;
    int   last;
    n     = s;
    n.cyc = s.cyc + 1;
    if (rst) begin
      n.cnt = 0; n.par = 0; n.mode = 0; n.inh = 0; n.irq = 0;
      n.wrapped = 0; n.rst_at = -1; n.q = 0; n.h = 0;
      return n;
    end
    rst_cycle = (s.rst_at == s.cyc);
    last      = s.mode ? p.s5 : p.s4;
    is_last   = (s.cnt == last);
    n.par     = !s.par;
    if (rst_cycle) begin
      n.cnt = 0; n.q = s.mode; n.h = s.mode; n.rst_at = -1; n.wrapped = 0;
    end else begin
      n.cnt     = is_last ? 0 : s.cnt + 1;
      n.q       = (s.cnt == p.s1) || (s.cnt == p.s2) || (s.cnt == p.s3) || is_last;
      n.h       = (s.cnt == p.s2) || is_last;
      n.wrapped = is_last && !s.mode;
    end
    set_irq = !s.mode && !s.inh && !rst_cycle &&
              ((s.cnt == p.s4 - 1) || (s.cnt == p.s4) || ((s.cnt == 0) && s.wrapped));
    if (wr && d[6])  n.irq = 0;
    else if (set_irq) n.irq = 1;
    else if (rd)      n.irq = 0;
    if (wr) begin
      n.mode   = d[7];
      n.inh    = d[6];
      n.rst_at = s.cyc + (s.par ? 3 : 4);
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed q/h/irq=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    ma = model_next(PA, ma, a_rst, a_wr, a_d, a_rd);
    mb = model_next(PB, mb, b_rst, b_wr, b_d, b_rd);
    e.sel = 1'b0; e.v = {ma.q, ma.h, irq_exp(ma.irq)}; e.cyc = ma.cyc;
    sb.push_back(e);
    e.sel = 1'b1; e.v = {mb.q, mb.h, irq_exp(mb.irq)}; e.cyc = mb.cyc;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel)
        check($sformatf("small cyc %0d", e.cyc), {b_q, b_h, b_irq}, e.v);
      else
        check($sformatf("ntsc cyc %0d", e.cyc), {a_q, a_h, a_irq}, e.v);
    end
  endtask

  task automatic cyc(input bit sel, input bit wr, input logic [7:0] d, input bit rd);
    if (sel) begin b_wr = wr; b_d = d; b_rd = rd; end
    else     begin a_wr = wr; a_d = d; a_rd = rd; end
    tick();
    a_wr = 1'b0; a_rd = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
  endtask

  task automatic run_until_cnt(input bit sel, input int target, input int bound);
    int n = 0;
    while (((sel ? mb.cnt : ma.cnt) != target) && (n < bound)) begin
      cyc(sel, 1'b0, 8'h00, 1'b0);
      n++;
    end
    if ((sel ? mb.cnt : ma.cnt) != target) begin
      miscompares++;
      $error("FAIL wait_cnt sel=%0d reached=%0d required=%0d", sel,
             sel ? mb.cnt : ma.cnt, target);
    end
  endtask

  task automatic run_until_par(input bit sel, input bit par);
    int n = 0;
    while (((sel ? mb.par : ma.par) != par) && (n < 4)) begin
      cyc(sel, 1'b0, 8'h00, 1'b0);
      n++;
    end
  endtask

  initial begin
    a_rst = 1'b1; a_wr = 1'b0; a_d = '0; a_rd = 1'b0;
    b_rst = 1'b1; b_wr = 1'b0; b_d = '0; b_rd = 1'b0;
    ma = '0;
    mb = '0;
    @(negedge clk_i);
    repeat (3) tick();
    check("reset_outputs", {a_q, a_h, a_irq}, 3'b000);
    a_rst = 1'b0;

    // 4-step frame from reset; read status on the last step cycle (set wins)
    run_until_cnt(1'b0, PA.s4, 40000);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("rd_on_set_cycle", {a_q, a_h, a_irq}, {2'b11, irq_exp(1'b1)});

    // read at cnt 100 of the next frame clears the flag
    run_until_cnt(1'b0, 100, 200);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("rd_clears_irq", {a_q, a_h, a_irq}, 3'b000);

    // 4-step write on even parity: 4-cycle delay, no immediate strobes
    run_until_par(1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    repeat (12) tick();

    // 5-step write on odd parity: reset 3 cycles later, strobes next cycle
    run_until_par(1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'h80, 1'b0);
    repeat (3) tick();
    check("5step_reset_strobe", {a_q, a_h, a_irq}, 3'b110);
    run_until_cnt(1'b0, PA.s5, 40000);
    repeat (4) tick();

    // second write two cycles after the first restarts the delay
    cyc(1'b0, 1'b1, 8'h80, 1'b0);
    tick();
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    repeat (10) tick();

    // short-step instance: inhibit write on a set cycle while the flag is 1
    b_rst = 1'b0;
    run_until_cnt(1'b1, PB.s4, 200);
    cyc(1'b1, 1'b1, 8'h40, 1'b0);
    check("inhibit_clears_irq", {b_q, b_h, b_irq}, 3'b110);
    repeat (250) tick();

    // reset on the step-2 cycle drops the half strobe and restarts counting
    run_until_cnt(1'b1, PB.s2, 200);
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    check("rst_drops_half", {b_q, b_h, b_irq}, 3'b000);
    repeat (200) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
